aes_round_ctrl: RTL and testbench

Sequencing controller for the iterative AES-128 encryption datapath. It accepts one block-start request, then issues single-cycle enable pulses to the registered SubBytes, ShiftRows, MixColumns and AddRoundKey stages in AES order, over NUM_ROUNDS rounds. It requests round keys from the key-expansion unit and stalls until each key is available. It presents a completion handshake to the consumer. The block carries no state data; it drives only control signals.

---
 rtl/aes_round_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl - sequencing controller for an iterative AES-128 encryption datapath.
// After a start it runs the initial AddRoundKey, then SubBytes/ShiftRows/MixColumns/
// AddRoundKey for each round (the last round has no MixColumns). It stalls each key stage
// on key_ready and finishes with an out_valid/out_ready handshake.
// Optional feature: define AES_ROUND_CTRL_ABORT_EN to add the abort input.
`timescale 1ns/1ps
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int STAGE_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       key_ready,
    output logic       key_req,
    output logic       en_sub,
    output logic       en_shift,
    output logic       en_mix,
    output logic       en_ark,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, OUT} state_t;

    // Dwell counter holds the number of cycles left after the current one in a stage.
    localparam int             CW         = (STAGE_LAT > 1) ? $clog2(STAGE_LAT + 1) : 1;
    localparam logic [CW-1:0]  DWELL_LAST = CW'(STAGE_LAT - 1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [3:0]     LAST_IDX   = 4'(NUM_ROUNDS);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
    // An abort only matters while a block is in flight; in IDLE it is ignored.
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Single-process FSM: state, dwell counter and every output are registered here.
    always_ff @(posedge clk) begin
        if (rst || abort_hit) begin
            state       <= IDLE;
            cnt         <= '0;
            start_ready <= 1'b1;
            key_req     <= 1'b0;
            en_sub      <= 1'b0;
            en_shift    <= 1'b0;
            en_mix      <= 1'b0;
            en_ark      <= 1'b0;
            round_idx   <= '0;
            last_round  <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            en_sub   <= 1'b0;
            en_shift <= 1'b0;
            en_mix   <= 1'b0;
            en_ark   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= INIT_ARK;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        key_req     <= 1'b1;
                        round_idx   <= '0;
                        last_round  <= 1'b0;
                    end
                end
                INIT_ARK, ARK: begin
                    // key_req high means the stage is still waiting for its round key.
                    if (key_req) begin
                        if (key_ready) begin
                            key_req <= 1'b0;
                            en_ark  <= 1'b1;
                            cnt     <= DWELL_LAST;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (state == ARK && round_idx == LAST_IDX) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        state      <= SUB;
                        en_sub     <= 1'b1;
                        cnt        <= DWELL_LAST;
                        round_idx  <= round_idx + 4'd1;
                        last_round <= ((round_idx + 4'd1) == LAST_IDX);
                    end
                end
                SUB: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state    <= SHIFT;
                        en_shift <= 1'b1;
                        cnt      <= DWELL_LAST;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (round_idx < LAST_IDX) begin
                        state  <= MIX;
                        en_mix <= 1'b1;
                        cnt    <= DWELL_LAST;
                    end else begin
                        // Final round skips MixColumns; a ready key pulses ARK on entry.
                        state <= ARK;
                        if (key_ready) begin
                            en_ark <= 1'b1;
                            cnt    <= DWELL_LAST;
                        end else begin
                            key_req <= 1'b1;
                        end
                    end
                end
                MIX: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state <= ARK;
                        if (key_ready) begin
                            en_ark <= 1'b1;
                            cnt    <= DWELL_LAST;
                        end else begin
                            key_req <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        round_idx   <= '0;
                        last_round  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl - self-checking bench for aes_round_ctrl.
// Two instances (STAGE_LAT=1 and STAGE_LAT=3) are driven one at a time. A schedule model
// (ordered stage list plus nominal issue times) predicts every output after each edge.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    localparam int          N         = 10;
    localparam int          NST       = 1 + 4 * (N - 1) + 3;
    localparam logic [12:0] RESET_VEC = 13'h0020;

    logic clk = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    logic       rst         [2];
    logic       start_valid [2];
    logic       start_ready [2];
    logic       key_ready   [2];
    logic       key_req     [2];
    logic       en_sub      [2];
    logic       en_shift    [2];
    logic       en_mix      [2];
    logic       en_ark      [2];
    logic [3:0] round_idx   [2];
    logic       last_round  [2];
    logic       out_valid   [2];
    logic       out_ready   [2];
    logic       abort       [2];
    logic       busy        [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes_round_ctrl #(.NUM_ROUNDS(N), .STAGE_LAT(g == 0 ? 1 : 3)) dut (
            .clk(clk),
            .rst(rst[g]),
            .start_valid(start_valid[g]),
            .start_ready(start_ready[g]),
            .key_ready(key_ready[g]),
            .key_req(key_req[g]),
            .en_sub(en_sub[g]),
            .en_shift(en_shift[g]),
            .en_mix(en_mix[g]),
            .en_ark(en_ark[g]),
            .round_idx(round_idx[g]),
            .last_round(last_round[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
`ifdef AES_ROUND_CTRL_ABORT_EN
            .abort(abort[g]),
`endif
            .busy(busy[g])
        );
    end

    // Stage codes: 0 SubBytes, 1 ShiftRows, 2 MixColumns, 3 AddRoundKey.
    int order [$];
    int m_lat, m_pos, m_nom, m_entry, m_round;
    bit m_idle, m_sub, m_shift, m_mix, m_ark, m_kreq, m_ov;
    int cyc, n_checks, n_fail;
    int r_rise, r_sub, r_shift, r_mix, r_ark, r_ov, r_kreq;
    bit found, r_done;

    typedef struct {
        int k;
        int stall_round;
        int stall_len;
        int out_wait;
        bit keep_start;
        int exp_rise;
        int exp_mix;
        int exp_ark;
        int exp_ov;
        int exp_kreq;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [12:0] dut_vec(input int k);
        return {en_sub[k], en_shift[k], en_mix[k], en_ark[k], key_req[k], out_valid[k],
                busy[k], start_ready[k], last_round[k], round_idx[k]};
    endfunction

    function automatic logic [12:0] model_vec();
        logic [3:0] r;
        r = m_round[3:0];
        return {m_sub, m_shift, m_mix, m_ark, m_kreq, m_ov, !m_idle, m_idle, (m_round == N), r};
    endfunction

    // Advance the schedule model by one clock edge with the inputs sampled at that edge.
    function automatic void model_edge(input int e, input logic sv, input logic kr,
                                       input logic orr, input logic rs, input logic ab);
        int st;
        m_sub = 0; m_shift = 0; m_mix = 0; m_ark = 0; m_kreq = 0;
        if (rs || (ab && !m_idle)) begin
            m_idle = 1; m_round = 0; m_ov = 0;
        end else if (m_idle) begin
            if (sv) begin
                m_idle = 0; m_pos = 0; m_entry = e; m_nom = e + 1; m_round = 0; m_kreq = 1;
            end
        end else if (m_pos < NST) begin
            st = order[m_pos];
            if (st == 3) begin
                if (e >= m_nom && kr) begin
                    m_ark = 1; m_pos++; m_nom = e + m_lat; m_entry = m_nom;
                end else if (e >= m_entry) begin
                    m_kreq = 1;
                end
            end else if (e == m_nom) begin
                case (st)
                    0: begin m_sub = 1; m_round++; end
                    1: m_shift = 1;
                    default: m_mix = 1;
                endcase
                m_pos++; m_nom = e + m_lat; m_entry = m_nom;
            end
        end else if (e == m_nom) begin
            m_ov = 1;
        end else if (e > m_nom && orr) begin
            m_idle = 1; m_ov = 0; m_round = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int k);
        @(posedge clk);
        cyc++;
        m_lat = (k == 0) ? 1 : 3;
        model_edge(cyc, start_valid[k], key_ready[k], out_ready[k], rst[k], abort[k]);
        #1;
        check($sformatf("outputs_dut%0d", k), 32'(dut_vec(k)), 32'(model_vec()));
    endtask

    task automatic run_block(input int k, input int stall_round, input int stall_len,
                             input int out_wait, input bit keep_start);
        int t_acc;
        int stall_left;
        t_acc = cyc + 1;
        stall_left = stall_len;
        r_done = 0; r_rise = -1;
        r_sub = 0; r_shift = 0; r_mix = 0; r_ark = 0; r_ov = 0; r_kreq = 0;
        start_valid[k] = 1'b1;
        out_ready[k] = 1'b0;
        for (int i = 0; i < 1000 && !r_done; i++) begin
            key_ready[k] = 1'b1;
            if (stall_left > 0 && !m_idle && m_pos < NST && order[m_pos] == 3 &&
                m_round == stall_round && cyc + 1 >= m_entry) begin
                key_ready[k] = 1'b0;
                stall_left--;
            end
            out_ready[k] = (r_ov > out_wait);
            if (!keep_start && cyc >= t_acc) start_valid[k] = 1'b0;
            tick(k);
            if (en_sub[k]) r_sub++;
            if (en_shift[k]) r_shift++;
            if (en_mix[k]) r_mix++;
            if (en_ark[k]) r_ark++;
            if (key_req[k]) r_kreq++;
            if (out_valid[k]) begin
                r_ov++;
                if (r_rise < 0) r_rise = cyc - t_acc;
            end
            r_done = (cyc > t_acc) && m_idle;
        end
        out_ready[k] = 1'b0;
        key_ready[k] = 1'b1;
        check("block_completed", 32'(r_done), 32'd1);
    endtask

    task automatic random_phase(input int k, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            start_valid[k] = ($urandom_range(0, 1) == 1);
            key_ready[k]   = ($urandom_range(0, 9) < 7);
            out_ready[k]   = ($urandom_range(0, 9) < 4);
            rst[k]         = ($urandom_range(0, 299) == 0);
`ifdef AES_ROUND_CTRL_ABORT_EN
            abort[k]       = ($urandom_range(0, 149) == 0);
`endif
            tick(k);
        end
        start_valid[k] = 1'b0; key_ready[k] = 1'b1; out_ready[k] = 1'b1;
        rst[k] = 1'b0; abort[k] = 1'b0;
        for (int i = 0; i < 600 && !m_idle; i++) tick(k);
        check($sformatf("drain_idle_dut%0d", k), 32'(busy[k]), 32'd0);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        order.push_back(3);
        for (int r = 1; r < N; r++) begin
            order.push_back(0); order.push_back(1); order.push_back(2); order.push_back(3);
        end
        order.push_back(0); order.push_back(1); order.push_back(3);

        tbl[0] = '{0, -1, 0, 0, 1'b0, 41, 9, 11, 1, 1};
        tbl[1] = '{0, 4, 5, 0, 1'b0, 46, 9, 11, 1, 6};
        tbl[2] = '{0, -1, 0, 3, 1'b1, 41, 9, 11, 4, 1};
        tbl[3] = '{0, 0, 2, 0, 1'b0, 43, 9, 11, 1, 3};
        tbl[4] = '{1, -1, 0, 0, 1'b0, 121, 9, 11, 1, 1};
        tbl[5] = '{1, 9, 2, 1, 1'b0, 123, 9, 11, 2, 3};

        cyc = 0; n_checks = 0; n_fail = 0;
        m_idle = 1; m_round = 0; m_pos = 0; m_nom = 0; m_entry = 0; m_lat = 1;
        m_sub = 0; m_shift = 0; m_mix = 0; m_ark = 0; m_kreq = 0; m_ov = 0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; start_valid[k] = 1'b0; key_ready[k] = 1'b1;
            out_ready[k] = 1'b0; abort[k] = 1'b0;
        end

        // Reset, then hold on the first cycle after release.
        start_valid[0] = 1'b1;
        repeat (3) tick(0);
        start_valid[0] = 1'b0;
        check("reset_vec_dut0", 32'(dut_vec(0)), 32'(RESET_VEC));
        check("reset_vec_dut1", 32'(dut_vec(1)), 32'(RESET_VEC));
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick(0);
        check("reset_hold_dut0", 32'(dut_vec(0)), 32'(RESET_VEC));
        check("reset_hold_dut1", 32'(dut_vec(1)), 32'(RESET_VEC));

        // Directed blocks with hand-derived latencies and pulse counts.
        for (int i = 0; i < 6; i++) begin
            run_block(tbl[i].k, tbl[i].stall_round, tbl[i].stall_len, tbl[i].out_wait, tbl[i].keep_start);
            check($sformatf("row%0d_out_valid_rise", i), 32'(r_rise), 32'(tbl[i].exp_rise));
            check($sformatf("row%0d_en_mix_count", i), 32'(r_mix), 32'(tbl[i].exp_mix));
            check($sformatf("row%0d_en_ark_count", i), 32'(r_ark), 32'(tbl[i].exp_ark));
            check($sformatf("row%0d_stage_total", i), 32'(r_sub + r_shift + r_mix + r_ark), 32'd40);
            check($sformatf("row%0d_out_valid_cycles", i), 32'(r_ov), 32'(tbl[i].exp_ov));
            check($sformatf("row%0d_key_req_cycles", i), 32'(r_kreq), 32'(tbl[i].exp_kreq));
            if (tbl[i].keep_start)
                check($sformatf("row%0d_idle_after_handshake", i), 32'(dut_vec(tbl[i].k)), 32'(RESET_VEC));
        end

        // Reset during round 6 MixColumns, then a clean block.
        start_valid[0] = 1'b1; key_ready[0] = 1'b1; out_ready[0] = 1'b0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(0);
            start_valid[0] = 1'b0;
            found = en_mix[0] && (round_idx[0] == 4'd6);
        end
        check("mid_rst_reached_mix6", 32'(found), 32'd1);
        rst[0] = 1'b1;
        tick(0);
        check("mid_rst_outputs", 32'(dut_vec(0)), 32'(RESET_VEC));
        rst[0] = 1'b0;
        tick(0);
        check("mid_rst_no_pulses", 32'(dut_vec(0)), 32'(RESET_VEC));
        run_block(0, -1, 0, 0, 1'b0);
        check("after_rst_out_valid_rise", 32'(r_rise), 32'd41);

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort together with out_ready in OUT.
        start_valid[0] = 1'b1; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(0);
            start_valid[0] = 1'b0;
            found = out_valid[0];
        end
        check("abort_reached_out", 32'(found), 32'd1);
        abort[0] = 1'b1; out_ready[0] = 1'b1;
        tick(0);
        check("abort_in_out", 32'(dut_vec(0)), 32'(RESET_VEC));
        abort[0] = 1'b0; out_ready[0] = 1'b0;
        // Abort during a key stall.
        start_valid[0] = 1'b1; key_ready[0] = 1'b0;
        tick(0);
        start_valid[0] = 1'b0;
        tick(0); tick(0);
        check("abort_stall_key_req", 32'(key_req[0]), 32'd1);
        abort[0] = 1'b1;
        tick(0);
        check("abort_stall_key_req_drop", 32'(key_req[0]), 32'd0);
        abort[0] = 1'b0; key_ready[0] = 1'b1;
        // Abort in IDLE does not block a start.
        abort[0] = 1'b1; start_valid[0] = 1'b1;
        tick(0);
        check("abort_idle_accept", 32'(busy[0]), 32'd1);
        start_valid[0] = 1'b0;
        tick(0);
        check("abort_after_accept", 32'(busy[0]), 32'd0);
        abort[0] = 1'b0;
`endif

        // Randomized traffic on each instance.
        random_phase(0, 1500);
        random_phase(1, 1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
